// File: rtl/pf_pkg.sv
// ---------------------------------------------------------------------------
// pf_pkg : shared mode encoding, latency and default widths for particle_filter_v3. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pf_pkg;

  localparam int PF_DATA_WIDTH = 16;
  localparam int PF_ADDR_WIDTH = 11;
  localparam int PF_TAP_NUM    = 2;
  localparam int PF_LATENCY    = 3;

  typedef enum logic [1:0] {
    PF_MODE_CURR = 2'd0,
    PF_MODE_OR   = 2'd1,
    PF_MODE_AND  = 2'd2,
    PF_MODE_RSVD = 2'd3
  } pf_mode_e;

  // all_ready_hit is 1 when no tap is ready, so AND mode degenerates to curr.
  function automatic logic pf_combine(input pf_mode_e mode, input logic curr_hit,
                                      input logic any_tap_hit, input logic all_ready_hit);
    logic res;
    case (mode)
      PF_MODE_OR:  res = curr_hit | any_tap_hit;
      PF_MODE_AND: res = curr_hit & all_ready_hit;
      default:     res = curr_hit;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/particle_cache_sdpram.sv
// ---------------------------------------------------------------------------
// particle_cache_sdpram : simple dual-port RAM, read-first, registered 1-cycle read. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module particle_cache_sdpram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/particle_filter_v3.sv
// ---------------------------------------------------------------------------
// particle_filter_v3 : 3-stage haze-subtracted threshold filter with spaced history taps. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module particle_filter_v3
  import pf_pkg::*;
#(
  parameter int DATA_WIDTH = PF_DATA_WIDTH,
  parameter int ADDR_WIDTH = PF_ADDR_WIDTH,
  parameter int TAP_NUM    = PF_TAP_NUM
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] light_spot_spacing_i,
  input  logic [1:0]            filter_mode_i,
  input  logic                  laser_delay_vld_i,
  input  logic                  laser_acc_flag_i,
  input  logic                  laser_vld_i,
  input  logic [DATA_WIDTH-1:0] laser_data_i,
  input  logic [DATA_WIDTH-1:0] laser_haze_data_i,
  input  logic [DATA_WIDTH-1:0] filter_curr_thre_i,
  input  logic [DATA_WIDTH-1:0] filter_cache_thre_i,
  output logic                  filter_delay_vld_o,
  output logic                  filter_acc_flag_o,
  output logic                  filter_vld_o,
  output logic [DATA_WIDTH-1:0] filter_data_o,
  output logic [DATA_WIDTH-1:0] filter_haze_data_o,
  output logic [DATA_WIDTH-1:0] filter_haze_hub_o,
  output logic                  filter_curr_result_o,
  output logic [TAP_NUM-1:0]    filter_cache_result_o,
  output logic                  filter_result_o,
  output logic [TAP_NUM-1:0]    filter_cache_ready_o
);

  localparam int KW = ADDR_WIDTH + 3;
  localparam logic [KW-1:0] MAX_OFF = {3'b000, {ADDR_WIDTH{1'b1}}};

  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] fill_q, fill_d, fill_eff;
  logic [ADDR_WIDTH-1:0] spacing_q;
  logic [TAP_NUM-1:0]    tap_rdy_now, tap_rdy_live, cache_ready_q;
  logic                  ram_we;

  logic                  s1_vld_q;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_haze_q, s1_curr_thre_q, s1_cache_thre_q;
  pf_mode_e              s1_mode_q;
  logic [TAP_NUM-1:0]    s1_rdy_q;

  logic [DATA_WIDTH:0]   hub_diff;
  logic [DATA_WIDTH-1:0] hub;
  logic                  curr_hit;
  logic [TAP_NUM-1:0]    tap_hit;

  logic                  s2_vld_q, s2_curr_hit_q;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_haze_q, s2_hub_q;
  logic [TAP_NUM-1:0]    s2_tap_hit_q, s2_rdy_q;
  pf_mode_e              s2_mode_q;

  logic [PF_LATENCY-1:0] dly_q, acc_q;
  logic                  out_vld_q, out_curr_q, out_res_q;
  logic [DATA_WIDTH-1:0] out_data_q, out_haze_q, out_hub_q;
  logic [TAP_NUM-1:0]    out_cache_q;

  // A spacing change invalidates history for the sample arriving this very cycle.
  always_comb begin
    fill_eff  = (light_spot_spacing_i != spacing_q) ? '0 : fill_q;
    fill_d    = fill_eff;
    wr_addr_d = wr_addr_q;
    if (laser_vld_i) begin
      wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
      if (fill_eff != {ADDR_WIDTH{1'b1}}) begin
        fill_d = fill_eff + ADDR_WIDTH'(1);
      end
    end
  end

  assign ram_we = laser_vld_i & ~rst_i;

  for (genvar k = 0; k < TAP_NUM; k++) begin : g_tap
    logic [KW-1:0]           off;
    logic [ADDR_WIDTH-1:0]   raddr;
    logic [2*DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH:0]     diff;

    assign off   = KW'(k + 1) * {3'b000, light_spot_spacing_i};
    assign raddr = wr_addr_q - off[ADDR_WIDTH-1:0];

    assign tap_rdy_now[k]  = (light_spot_spacing_i != '0) && (off <= MAX_OFF) &&
                             ({3'b000, fill_eff} >= off);
    assign tap_rdy_live[k] = (light_spot_spacing_i != '0) && (off <= MAX_OFF) &&
                             ({3'b000, fill_d} >= off);

    particle_cache_sdpram #(
      .DATA_WIDTH (2*DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .waddr_i (wr_addr_q),
      .wdata_i ({laser_haze_data_i, laser_data_i}),
      .raddr_i (raddr),
      .rdata_o (rdata)
    );

    assign diff       = {1'b0, rdata[DATA_WIDTH-1:0]} - {1'b0, rdata[2*DATA_WIDTH-1:DATA_WIDTH]};
    assign tap_hit[k] = s1_rdy_q[k] && !diff[DATA_WIDTH] &&
                        (diff[DATA_WIDTH-1:0] > s1_cache_thre_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_addr_q       <= '0;
      fill_q          <= '0;
      spacing_q       <= '0;
      cache_ready_q   <= '0;
      s1_vld_q        <= 1'b0;
      s1_data_q       <= '0;
      s1_haze_q       <= '0;
      s1_curr_thre_q  <= '0;
      s1_cache_thre_q <= '0;
      s1_mode_q       <= PF_MODE_CURR;
      s1_rdy_q        <= '0;
    end else begin
      wr_addr_q       <= wr_addr_d;
      fill_q          <= fill_d;
      spacing_q       <= light_spot_spacing_i;
      cache_ready_q   <= tap_rdy_live;
      s1_vld_q        <= laser_vld_i;
      s1_data_q       <= laser_data_i;
      s1_haze_q       <= laser_haze_data_i;
      s1_curr_thre_q  <= filter_curr_thre_i;
      s1_cache_thre_q <= filter_cache_thre_i;
      s1_mode_q       <= pf_mode_e'(filter_mode_i);
      s1_rdy_q        <= tap_rdy_now;
    end
  end

  assign hub_diff = {1'b0, s1_data_q} - {1'b0, s1_haze_q};
  assign hub      = hub_diff[DATA_WIDTH] ? '0 : hub_diff[DATA_WIDTH-1:0];
  assign curr_hit = hub > s1_curr_thre_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_vld_q      <= 1'b0;
      s2_data_q     <= '0;
      s2_haze_q     <= '0;
      s2_hub_q      <= '0;
      s2_curr_hit_q <= 1'b0;
      s2_tap_hit_q  <= '0;
      s2_rdy_q      <= '0;
      s2_mode_q     <= PF_MODE_CURR;
    end else begin
      s2_vld_q      <= s1_vld_q;
      s2_data_q     <= s1_data_q;
      s2_haze_q     <= s1_haze_q;
      s2_hub_q      <= hub;
      s2_curr_hit_q <= curr_hit;
      s2_tap_hit_q  <= tap_hit;
      s2_rdy_q      <= s1_rdy_q;
      s2_mode_q     <= s1_mode_q;
    end
  end

  // Result fields only move on valid samples; data fields track the delay line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dly_q       <= '0;
      acc_q       <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_haze_q  <= '0;
      out_hub_q   <= '0;
      out_curr_q  <= 1'b0;
      out_cache_q <= '0;
      out_res_q   <= 1'b0;
    end else begin
      dly_q      <= {dly_q[PF_LATENCY-2:0], laser_delay_vld_i};
      acc_q      <= {acc_q[PF_LATENCY-2:0], laser_acc_flag_i};
      out_vld_q  <= s2_vld_q;
      out_data_q <= s2_data_q;
      out_haze_q <= s2_haze_q;
      out_hub_q  <= s2_hub_q;
      if (s2_vld_q) begin
        out_curr_q  <= s2_curr_hit_q;
        out_cache_q <= s2_tap_hit_q;
        out_res_q   <= pf_combine(s2_mode_q, s2_curr_hit_q, |s2_tap_hit_q,
                                  &(s2_tap_hit_q | ~s2_rdy_q));
      end
    end
  end

  assign filter_delay_vld_o    = dly_q[PF_LATENCY-1];
  assign filter_acc_flag_o     = acc_q[PF_LATENCY-1];
  assign filter_vld_o          = out_vld_q;
  assign filter_data_o         = out_data_q;
  assign filter_haze_data_o    = out_haze_q;
  assign filter_haze_hub_o     = out_hub_q;
  assign filter_curr_result_o  = out_curr_q;
  assign filter_cache_result_o = out_cache_q;
  assign filter_result_o       = out_res_q;
  assign filter_cache_ready_o  = cache_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_particle_filter_v3.sv
// ---------------------------------------------------------------------------
// tb_particle_filter_v3 : randomized bench with a sample-history reference model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_particle_filter_v3;

  localparam int DW    = 16;
  localparam int AW    = 11;
  localparam int TAPS  = 3;
  localparam int DEPTH = 1 << AW;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [AW-1:0]   sp_i;
  logic [1:0]      mode_i;
  logic            dly_i, acc_i, vld_i;
  logic [DW-1:0]   data_i, haze_i, cthre_i, kthre_i;
  logic            dly_o, acc_o, vld_o, curr_o, res_o;
  logic [DW-1:0]   data_o, haze_o, hub_o;
  logic [TAPS-1:0] cache_o, ready_o;

  always #5 clk_i = ~clk_i;

  particle_filter_v3 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAP_NUM(TAPS)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .light_spot_spacing_i  (sp_i),
    .filter_mode_i         (mode_i),
    .laser_delay_vld_i     (dly_i),
    .laser_acc_flag_i      (acc_i),
    .laser_vld_i           (vld_i),
    .laser_data_i          (data_i),
    .laser_haze_data_i     (haze_i),
    .filter_curr_thre_i    (cthre_i),
    .filter_cache_thre_i   (kthre_i),
    .filter_delay_vld_o    (dly_o),
    .filter_acc_flag_o     (acc_o),
    .filter_vld_o          (vld_o),
    .filter_data_o         (data_o),
    .filter_haze_data_o    (haze_o),
    .filter_haze_hub_o     (hub_o),
    .filter_curr_result_o  (curr_o),
    .filter_cache_result_o (cache_o),
    .filter_result_o       (res_o),
    .filter_cache_ready_o  (ready_o)
  );

  typedef struct {
    int            due;
    bit            vld;
    bit            dly;
    bit            acc;
    int            data;
    int            haze;
    int            hub;
    bit            curr;
    bit [TAPS-1:0] cache;
    bit            res;
  } exp_t;

  // Reference model state: complete sample history plus bookkeeping.
  int            hist_d [DEPTH];
  int            hist_h [DEPTH];
  int            waddr, fill, sp_reg, cyc;
  bit [TAPS-1:0] exp_ready;
  bit            last_curr, last_res;
  bit [TAPS-1:0] last_cache;
  exp_t          q[$];
  int            n_checks, n_pass;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit tap_ready(input int k, input int sp, input int f);
    int off;
    off = k * sp;
    return (sp != 0) && (off <= DEPTH - 1) && (f >= off);
  endfunction

  task automatic step();
    exp_t e;
    bit   was_rst;
    was_rst = rst_i;
    if (rst_i) begin
      q.delete();
      fill = 0; sp_reg = 0; waddr = 0; exp_ready = '0;
      last_curr = 0; last_res = 0; last_cache = '0;
      e.due = cyc + 1; q.push_back(e);
      e.due = cyc + 2; q.push_back(e);
    end else begin
      int  sp, fe, d, h, ct, kt;
      bit  any_hit, all_hit;
      sp = int'(sp_i); d = int'(data_i); h = int'(haze_i);
      ct = int'(cthre_i); kt = int'(kthre_i);
      fe = (sp != sp_reg) ? 0 : fill;
      e.due  = cyc + 2;
      e.vld  = vld_i; e.dly = dly_i; e.acc = acc_i;
      e.data = d; e.haze = h;
      e.hub  = (d > h) ? d - h : 0;
      e.curr = e.hub > ct;
      any_hit = 0; all_hit = 1;
      for (int k = 1; k <= TAPS; k++) begin
        if (tap_ready(k, sp, fe)) begin
          int a, od, oh;
          bit hit;
          a  = (((waddr - k * sp) % DEPTH) + DEPTH) % DEPTH;
          od = hist_d[a]; oh = hist_h[a];
          hit = (od > oh) && ((od - oh) > kt);
          e.cache[k-1] = hit;
          any_hit |= hit;
          all_hit &= hit;
        end
      end
      case (int'(mode_i))
        1:       e.res = e.curr | any_hit;
        2:       e.res = e.curr & all_hit;
        default: e.res = e.curr;
      endcase
      if (vld_i) begin
        hist_d[waddr] = d; hist_h[waddr] = h;
        waddr = (waddr + 1) % DEPTH;
        fill  = (fe + 1 > DEPTH - 1) ? DEPTH - 1 : fe + 1;
      end else begin
        fill = fe;
      end
      sp_reg = sp;
      for (int k = 1; k <= TAPS; k++) exp_ready[k-1] = tap_ready(k, sp, fill);
      q.push_back(e);
    end

    @(posedge clk_i);
    #1;
    if (was_rst) begin
      check_val("rst_flags", {vld_o, dly_o, acc_o, curr_o, res_o}, 0);
      check_val("rst_data", {data_o, haze_o}, 0);
      check_val("rst_hub", hub_o, 0);
      check_val("rst_cache_ready", {cache_o, ready_o}, 0);
    end else if (q.size() == 0 || q[0].due != cyc) begin
      check_val("schedule", 0, 1);
    end else begin
      e = q.pop_front();
      check_val("vld", vld_o, e.vld);
      check_val("delay_vld", dly_o, e.dly);
      check_val("acc_flag", acc_o, e.acc);
      if (e.vld) begin
        check_val("data", data_o, e.data);
        check_val("haze", haze_o, e.haze);
        check_val("hub", hub_o, e.hub);
        check_val("curr_result", curr_o, e.curr);
        check_val("cache_result", cache_o, e.cache);
        check_val("result", res_o, e.res);
        last_curr = e.curr; last_cache = e.cache; last_res = e.res;
      end else begin
        check_val("hold_results", {curr_o, cache_o, res_o}, {last_curr, last_cache, last_res});
      end
      check_val("cache_ready", ready_o, exp_ready);
    end
    cyc++;
  endtask

  task automatic drive(input int sp, input int md, input bit v, input int d, input int h,
                       input int ct, input int kt);
    sp_i    = AW'(sp);
    mode_i  = 2'(md);
    vld_i   = v;
    data_i  = DW'(d);
    haze_i  = DW'(h);
    cthre_i = DW'(ct);
    kthre_i = DW'(kt);
    dly_i   = 1'($urandom);
    acc_i   = 1'($urandom);
    step();
  endtask

  task automatic rand_phase(input int sp, input int n);
    for (int i = 0; i < n; i++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 80));
      drive(sp, int'($urandom_range(0, 3)), $urandom_range(0, 9) < 8, d,
            int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0;
    waddr = 0; fill = 0; sp_reg = 0; exp_ready = '0;
    last_curr = 0; last_res = 0; last_cache = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hist_d[i] = 0; hist_h[i] = 0;
    end

    rst_i = 1'b1;
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b0;

    // steady bright spot: taps become ready one spacing apart
    repeat (20) drive(4, 0, 1, 100, 20, 50, 50);
    // haze above data: clamped hub, no hit
    repeat (6) drive(4, 1, 1, 10, 30, 50, 50);

    rand_phase(4, 300);
    rand_phase(6, 200);

    // reset with samples in flight
    repeat (3) drive(6, 0, 1, 100, 20, 10, 10);
    rst_i = 1'b1;
    drive(6, 0, 1, 100, 20, 10, 10);
    rst_i = 1'b0;

    rand_phase(6, 100);
    rand_phase(0, 60);
    rand_phase(700, 2400);
    rand_phase(1023, 2300);
    rand_phase(1, 100);
    repeat (4) drive(1, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
